// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID output register for the decryption core.
// Ports: clk/rst_n, stall/branch in, imem req/addr/rdata, instr/pc/valid/halted out.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8,
  output logic        valid_out,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  state_t      stateQ, stateD;
  logic [31:0] pcQ, pcD;
  logic [31:0] inflightPcQ, inflightPcD;
  logic        inflightVQ, inflightVD;
  logic [31:0] instrQ, instrD;
  logic [31:0] pcOutQ, pcOutD;
  logic        validQ, validD;
  logic        haltedQ, haltedD;

  always_comb begin
    stateD      = stateQ;
    pcD         = pcQ;
    inflightPcD = inflightPcQ;
    inflightVD  = inflightVQ;
    instrD      = instrQ;
    pcOutD      = pcOutQ;
    validD      = validQ;
    haltedD     = haltedQ;
    imem_req    = 1'b0;
    unique case (stateQ)
      BOOT: stateD = RUN;
      RUN: begin
        imem_req = !stall;
        if (branch_taken) begin
          // Redirect flushes the word in flight and the output slot.
          pcD        = branch_target & 32'hFFFF_FFFC;
          inflightVD = 1'b0;
          validD     = 1'b0;
        end else if (!stall) begin
          pcD         = pcQ + 32'd4;
          inflightVD  = 1'b1;
          inflightPcD = pcQ;
          validD      = inflightVQ;
          if (inflightVQ) begin
            instrD = imem_rdata;
            pcOutD = inflightPcQ;
            if (imem_rdata == HALT_WORD) begin
              inflightVD = 1'b0;
              stateD     = HALTED;
              haltedD    = 1'b1;
            end
          end
        end
      end
      HALTED: begin
        if (!stall) validD = 1'b0;
      end
      default: stateD = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ      <= BOOT;
      pcQ         <= RESET_PC;
      inflightPcQ <= 32'd0;
      inflightVQ  <= 1'b0;
      instrQ      <= 32'd0;
      pcOutQ      <= 32'd0;
      validQ      <= 1'b0;
      haltedQ     <= 1'b0;
    end else begin
      stateQ      <= stateD;
      pcQ         <= pcD;
      inflightPcQ <= inflightPcD;
      inflightVQ  <= inflightVD;
      instrQ      <= instrD;
      pcOutQ      <= pcOutD;
      validQ      <= validD;
      haltedQ     <= haltedD;
    end
  end

  assign imem_addr = pcQ;
  assign instr_out = instrQ;
  assign pc_out    = pcOutQ;
  assign pc_plus8  = pcOutQ + 32'd8;
  assign valid_out = validQ;
  assign halted    = haltedQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous instruction memory model.
// Memory word i holds i*0x11 unless a scenario overrides it.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;
  logic        valid_out;
  logic        halted;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [256];

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .pc_plus8     (pc_plus8),
    .valid_out    (valid_out),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_req) imem_rdata <= mem[imem_addr[9:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid got=%0h exp=0", valid_out); end
    tests++; if (instr_out !== 32'h0) begin fails++; $display("FAIL rst_instr got=%0h exp=0", instr_out); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL rst_pc got=%0h exp=0", pc_out); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted got=%0h exp=0", halted); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL boot_valid1 got=%0h exp=0", valid_out); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL boot_req got=%0h exp=1", imem_req); end
    step();
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL boot_valid2 got=%0h exp=0", valid_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL stream_valid%0d got=%0h exp=1", i, valid_out); end
      tests++; if (pc_out !== 32'(i * 4)) begin fails++; $display("FAIL stream_pc%0d got=%0h exp=%0h", i, pc_out, i * 4); end
      tests++; if (instr_out !== 32'(i * 'h11)) begin fails++; $display("FAIL stream_instr%0d got=%0h exp=%0h", i, instr_out, i * 'h11); end
      tests++; if (pc_plus8 !== 32'(i * 4 + 8)) begin fails++; $display("FAIL stream_plus8_%0d got=%0h exp=%0h", i, pc_plus8, i * 4 + 8); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req got=%0h exp=0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL stall_valid%0d got=%0h exp=1", i, valid_out); end
      tests++; if (pc_out !== 32'h8) begin fails++; $display("FAIL stall_pc%0d got=%0h exp=8", i, pc_out); end
      tests++; if (instr_out !== 32'h22) begin fails++; $display("FAIL stall_instr%0d got=%0h exp=22", i, instr_out); end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req%0d got=%0h exp=0", i, imem_req); end
    end
    stall = 1'b0;
    step();
    tests++; if (pc_out !== 32'hC) begin fails++; $display("FAIL unstall_pc0 got=%0h exp=c", pc_out); end
    tests++; if (instr_out !== 32'h33) begin fails++; $display("FAIL unstall_instr0 got=%0h exp=33", instr_out); end
    step();
    tests++; if (pc_out !== 32'h10) begin fails++; $display("FAIL unstall_pc1 got=%0h exp=10", pc_out); end
    tests++; if (instr_out !== 32'h44) begin fails++; $display("FAIL unstall_instr1 got=%0h exp=44", instr_out); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL br_valid0 got=%0h exp=0", valid_out); end
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL br_addr got=%0h exp=40", imem_addr); end
    step();
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL br_valid1 got=%0h exp=0", valid_out); end
    step();
    tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL br_valid2 got=%0h exp=1", valid_out); end
    tests++; if (pc_out !== 32'h40) begin fails++; $display("FAIL br_pc0 got=%0h exp=40", pc_out); end
    tests++; if (instr_out !== 32'h110) begin fails++; $display("FAIL br_instr0 got=%0h exp=110", instr_out); end
    step();
    tests++; if (pc_out !== 32'h44) begin fails++; $display("FAIL br_pc1 got=%0h exp=44", pc_out); end
    tests++; if (instr_out !== 32'h121) begin fails++; $display("FAIL br_instr1 got=%0h exp=121", instr_out); end
  endtask

  task automatic test_stall_branch();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL sb_valid0 got=%0h exp=0", valid_out); end
    tests++; if (imem_addr !== 32'h80) begin fails++; $display("FAIL sb_addr got=%0h exp=80", imem_addr); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL sb_req got=%0h exp=0", imem_req); end
    step();
    tests++; if (imem_addr !== 32'h80) begin fails++; $display("FAIL sb_addr_hold got=%0h exp=80", imem_addr); end
    stall = 1'b0;
    step();
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL sb_valid1 got=%0h exp=0", valid_out); end
    step();
    tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL sb_valid2 got=%0h exp=1", valid_out); end
    tests++; if (pc_out !== 32'h80) begin fails++; $display("FAIL sb_pc got=%0h exp=80", pc_out); end
    tests++; if (instr_out !== 32'h220) begin fails++; $display("FAIL sb_instr got=%0h exp=220", instr_out); end
  endtask

  task automatic test_misaligned();
    branch_taken = 1'b1;
    branch_target = 32'h4A;
    step();
    branch_taken = 1'b0;
    tests++; if (imem_addr !== 32'h48) begin fails++; $display("FAIL mis_addr got=%0h exp=48", imem_addr); end
    step();
    step();
    tests++; if (pc_out !== 32'h48) begin fails++; $display("FAIL mis_pc got=%0h exp=48", pc_out); end
    tests++; if (instr_out !== 32'h132) begin fails++; $display("FAIL mis_instr got=%0h exp=132", instr_out); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    step();
    branch_taken = 1'b0;
    step();
    step();
    tests++; if (pc_out !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_pc0 got=%0h exp=fffffff8", pc_out); end
    tests++; if (instr_out !== 32'h10DE) begin fails++; $display("FAIL wrap_instr0 got=%0h exp=10de", instr_out); end
    tests++; if (pc_plus8 !== 32'h0) begin fails++; $display("FAIL wrap_plus8 got=%0h exp=0", pc_plus8); end
    step();
    tests++; if (pc_out !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc1 got=%0h exp=fffffffc", pc_out); end
    tests++; if (instr_out !== 32'h10EF) begin fails++; $display("FAIL wrap_instr1 got=%0h exp=10ef", instr_out); end
    step();
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL wrap_pc2 got=%0h exp=0", pc_out); end
    tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL wrap_valid2 got=%0h exp=1", valid_out); end
  endtask

  task automatic test_halt();
    mem[8] = 32'hFFFF_FFFF;
    branch_taken = 1'b1;
    branch_target = 32'h1C;
    step();
    branch_taken = 1'b0;
    step();
    step();
    tests++; if (pc_out !== 32'h1C) begin fails++; $display("FAIL halt_pre_pc got=%0h exp=1c", pc_out); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_pre got=%0h exp=0", halted); end
    step();
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag got=%0h exp=1", halted); end
    tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL halt_valid got=%0h exp=1", valid_out); end
    tests++; if (pc_out !== 32'h20) begin fails++; $display("FAIL halt_pc got=%0h exp=20", pc_out); end
    tests++; if (instr_out !== 32'hFFFF_FFFF) begin fails++; $display("FAIL halt_instr got=%0h exp=ffffffff", instr_out); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL halt_req got=%0h exp=0", imem_req); end
    stall = 1'b1;
    step();
    tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL halt_stall_valid got=%0h exp=1", valid_out); end
    stall = 1'b0;
    step();
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL halt_drop_valid got=%0h exp=0", valid_out); end
    branch_taken = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_br_flag got=%0h exp=1", halted); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL halt_br_req got=%0h exp=0", imem_req); end
    tests++; if (imem_addr !== 32'h28) begin fails++; $display("FAIL halt_br_addr got=%0h exp=28", imem_addr); end
    step();
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL halt_br_valid got=%0h exp=0", valid_out); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL ar0_halted got=%0h exp=0", halted); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL ar0_pc got=%0h exp=0", pc_out); end
    tests++; if (instr_out !== 32'h0) begin fails++; $display("FAIL ar0_instr got=%0h exp=0", instr_out); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL ar0_addr got=%0h exp=0", imem_addr); end
    mem[8] = 32'h88;
    #3 rst_n = 1'b1;
    step();
    step();
    step();
    tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL ar0_refetch_valid got=%0h exp=1", valid_out); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL ar0_refetch_pc got=%0h exp=0", pc_out); end
    step();
    tests++; if (pc_out !== 32'h4) begin fails++; $display("FAIL ar1_pre_pc got=%0h exp=4", pc_out); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL ar1_valid got=%0h exp=0", valid_out); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL ar1_pc got=%0h exp=0", pc_out); end
    tests++; if (instr_out !== 32'h0) begin fails++; $display("FAIL ar1_instr got=%0h exp=0", instr_out); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL ar1_addr got=%0h exp=0", imem_addr); end
    #3 rst_n = 1'b1;
    step();
    step();
    step();
    tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL ar1_refetch_valid got=%0h exp=1", valid_out); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL ar1_refetch_pc got=%0h exp=0", pc_out); end
    step();
    tests++; if (instr_out !== 32'h11) begin fails++; $display("FAIL ar1_refetch_instr got=%0h exp=11", instr_out); end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 'h11);
    rst_n = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    imem_rdata = 32'h0;
    #2;
    test_reset();
    test_stall();
    test_branch();
    test_stall_branch();
    test_misaligned();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
